// File: rtl/tcm_bank_ctrl.sv
// Banked TCM controller: word-interleaved SRAM banks shared by imem/dmem,
// round-robin on same-bank conflicts, byte masking and error responses.
module tcm_bank_ctrl #(
    parameter int          NUM_BANKS  = 2,
    parameter int          BANK_DEPTH = 512,
    parameter int          BANK_AW    = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           imem_req_i,
    input  logic [31:0]                    imem_addr_i,
    output logic                           imem_req_ack_o,
    output logic [31:0]                    imem_rdata_o,
    output logic [1:0]                     imem_resp_o,
    input  logic                           dmem_req_i,
    input  logic                           dmem_cmd_i,
    input  logic [1:0]                     dmem_width_i,
    input  logic [31:0]                    dmem_addr_i,
    input  logic [31:0]                    dmem_wdata_i,
    output logic                           dmem_req_ack_o,
    output logic [31:0]                    dmem_rdata_o,
    output logic [1:0]                     dmem_resp_o,
    output logic [NUM_BANKS-1:0]           sram_csb_o,
    output logic [NUM_BANKS-1:0]           sram_web_o,
    output logic [4*NUM_BANKS-1:0]         sram_wmask_o,
    output logic [BANK_AW*NUM_BANKS-1:0]   sram_addr_o,
    output logic [32*NUM_BANKS-1:0]        sram_din_o,
    input  logic [32*NUM_BANKS-1:0]        sram_dout_i
);

    localparam int          LG  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int          BIW = (NUM_BANKS > 1) ? LG : 1;
    localparam logic [32:0] WIN = 33'(4 * NUM_BANKS * BANK_DEPTH);
    localparam logic [31:0] BMASK = 32'(NUM_BANKS - 1);

    localparam logic [1:0] RSP_IDLE = 2'b00;
    localparam logic [1:0] RSP_RDY  = 2'b01;
    localparam logic [1:0] RSP_ER   = 2'b10;

    logic [31:0]        i_off, d_off;
    logic [BIW-1:0]     i_bank, d_bank;
    logic [BANK_AW-1:0] i_row, d_row;
    logic               i_err, d_err, i_go, d_go, conflict, i_win, d_win;
    logic [31:0]        d_din;
    logic [3:0]         d_mask;
    logic               rr;

    logic [1:0]         i_resp_q, d_resp_q;
    logic [BIW-1:0]     i_bank_q, d_bank_q;
    logic               d_rd_q;

    // Offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
    assign i_off  = imem_addr_i - BASE_ADDR;
    assign d_off  = dmem_addr_i - BASE_ADDR;
    assign i_bank = BIW'((i_off >> 2) & BMASK);
    assign d_bank = BIW'((d_off >> 2) & BMASK);
    assign i_row  = BANK_AW'(i_off >> (2 + LG));
    assign d_row  = BANK_AW'(d_off >> (2 + LG));

    assign i_err = ({1'b0, i_off} >= WIN) || (imem_addr_i[1:0] != 2'b00);
    assign d_err = ({1'b0, d_off} >= WIN) || (dmem_width_i == 2'b11)
                || (dmem_width_i == 2'b01 && dmem_addr_i[0])
                || (dmem_width_i == 2'b10 && dmem_addr_i[1:0] != 2'b00);

    assign i_go     = imem_req_i && !i_err;
    assign d_go     = dmem_req_i && !d_err;
    assign conflict = i_go && d_go && (i_bank == d_bank);
    // rr = 0 favours dmem; it flips after every contended grant.
    assign i_win    = i_go && (!conflict || rr);
    assign d_win    = d_go && (!conflict || !rr);

    assign imem_req_ack_o = rst_n && imem_req_i && (i_err || i_win);
    assign dmem_req_ack_o = rst_n && dmem_req_i && (d_err || d_win);

    always_comb begin
        d_din  = dmem_wdata_i;
        d_mask = 4'b1111;
        case (dmem_width_i)
            2'b00: begin
                d_din  = {4{dmem_wdata_i[7:0]}};
                d_mask = 4'b0001 << dmem_addr_i[1:0];
            end
            2'b01: begin
                d_din  = {2{dmem_wdata_i[15:0]}};
                d_mask = 4'b0011 << dmem_addr_i[1:0];
            end
            default: ;
        endcase
        if (!dmem_cmd_i) d_mask = 4'b1111;
    end

    always_comb begin
        sram_csb_o   = '1;
        sram_web_o   = '1;
        sram_wmask_o = '0;
        sram_addr_o  = '0;
        sram_din_o   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (d_win && d_bank == BIW'(b)) begin
                sram_csb_o[b]                   = 1'b0;
                sram_web_o[b]                   = ~dmem_cmd_i;
                sram_wmask_o[4*b +: 4]          = d_mask;
                sram_addr_o[BANK_AW*b +: BANK_AW] = d_row;
                sram_din_o[32*b +: 32]          = dmem_cmd_i ? d_din : 32'h0;
            end else if (i_win && i_bank == BIW'(b)) begin
                sram_csb_o[b]                   = 1'b0;
                sram_wmask_o[4*b +: 4]          = 4'b1111;
                sram_addr_o[BANK_AW*b +: BANK_AW] = i_row;
            end
        end
        if (!rst_n) begin
            sram_csb_o = '1;
            sram_web_o = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_resp_q <= RSP_IDLE;
            d_resp_q <= RSP_IDLE;
            i_bank_q <= '0;
            d_bank_q <= '0;
            d_rd_q   <= 1'b0;
            rr       <= 1'b0;
        end else begin
            i_resp_q <= imem_req_ack_o ? (i_err ? RSP_ER : RSP_RDY) : RSP_IDLE;
            d_resp_q <= dmem_req_ack_o ? (d_err ? RSP_ER : RSP_RDY) : RSP_IDLE;
            i_bank_q <= i_bank;
            d_bank_q <= d_bank;
            d_rd_q   <= !dmem_cmd_i;
            if (conflict) rr <= !rr;
        end
    end

    assign imem_resp_o  = i_resp_q;
    assign dmem_resp_o  = d_resp_q;
    assign imem_rdata_o = (i_resp_q == RSP_RDY) ? sram_dout_i[32*int'(i_bank_q) +: 32] : 32'h0;
    assign dmem_rdata_o = (d_resp_q == RSP_RDY && d_rd_q)
                        ? sram_dout_i[32*int'(d_bank_q) +: 32] : 32'h0;

endmodule

// File: tb/tb_tcm_bank_ctrl.sv
// Directed bench for tcm_bank_ctrl with two behavioural SRAM banks attached.
module tb_tcm_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic        dmem_req = 1'b0;
    logic        dmem_cmd = 1'b0;
    logic [1:0]  dmem_width = 2'b10;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic [1:0]  sram_csb, sram_web;
    logic [7:0]  sram_wmask;
    logic [17:0] sram_addr;
    logic [63:0] sram_din, sram_dout;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [2][512];
    logic [31:0] dout [2];

    always #5 clk = ~clk;

    tcm_bank_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_req_ack_o(imem_ack),
        .imem_rdata_o(imem_rdata), .imem_resp_o(imem_resp),
        .dmem_req_i(dmem_req), .dmem_cmd_i(dmem_cmd), .dmem_width_i(dmem_width),
        .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata), .dmem_req_ack_o(dmem_ack),
        .dmem_rdata_o(dmem_rdata), .dmem_resp_o(dmem_resp),
        .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_wmask_o(sram_wmask),
        .sram_addr_o(sram_addr), .sram_din_o(sram_din), .sram_dout_i(sram_dout)
    );

    // Single-port macro model: masked write at the edge, read data the cycle after.
    assign sram_dout = {dout[1], dout[0]};
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!sram_csb[b]) begin
                if (!sram_web[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (sram_wmask[4*b+k])
                            mem[b][sram_addr[9*b +: 9]][8*k +: 8] <= sram_din[32*b + 8*k +: 8];
                end else begin
                    dout[b] <= mem[b][sram_addr[9*b +: 9]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dc,
                       input logic [1:0] dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        imem_req = ir; imem_addr = ia;
        dmem_req = dr; dmem_cmd = dc; dmem_width = dw; dmem_addr = da; dmem_wdata = dd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  ew [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ea [4] = '{32'h2, 32'h1, 32'h0, 32'h1000};

    initial begin
        for (int b = 0; b < 2; b++) begin
            dout[b] = '0;
            for (int r = 0; r < 512; r++) mem[b][r] = '0;
        end

        // Reset: requests present but nothing acknowledged or selected
        imem_req = 1'b1; dmem_req = 1'b1;
        #2;
        chk("rst_imem_ack", imem_ack, 0);
        chk("rst_dmem_ack", dmem_ack, 0);
        chk("rst_csb", sram_csb, 2'b11);
        chk("rst_web", sram_web, 2'b11);
        tick();
        chk("rst_imem_resp", imem_resp, 0);
        chk("rst_dmem_resp", dmem_resp, 0);
        chk("rst_rdata", {imem_rdata, dmem_rdata}, 0);
        @(negedge clk);
        imem_req = 1'b0; dmem_req = 1'b0;
        rst_n = 1'b1;

        // Word write 0xDEADBEEF @0x8 -> bank0 row1
        drv(0, 0, 1, 1, 2'b10, 32'h8, 32'hDEADBEEF);
        chk("w8_ack", dmem_ack, 1);
        chk("w8_csb", sram_csb, 2'b10);
        chk("w8_web", sram_web, 2'b10);
        chk("w8_mask", sram_wmask[3:0], 4'b1111);
        chk("w8_addr", sram_addr[8:0], 9'd1);
        chk("w8_din", sram_din[31:0], 32'hDEADBEEF);
        tick();
        chk("w8_resp", dmem_resp, 2'b01);
        chk("w8_rdata", dmem_rdata, 0);

        // Read-after-write on the next cycle
        drv(0, 0, 1, 0, 2'b10, 32'h8, 0);
        chk("r8_ack", dmem_ack, 1);
        chk("r8_csb_web", {sram_csb, sram_web}, 4'b1011);
        tick();
        chk("r8_resp", dmem_resp, 2'b01);
        chk("r8_rdata", dmem_rdata, 32'hDEADBEEF);

        // Byte write 0xA5 @0xD over 0x11223344 (bank1 row1)
        drv(0, 0, 1, 1, 2'b10, 32'hC, 32'h11223344);
        tick();
        drv(0, 0, 1, 1, 2'b00, 32'hD, 32'h000000A5);
        chk("wb_csb", sram_csb, 2'b01);
        chk("wb_mask", sram_wmask[7:4], 4'b0010);
        chk("wb_din", sram_din[63:32], 32'hA5A5A5A5);
        tick();
        drv(0, 0, 1, 0, 2'b10, 32'hC, 0);
        tick();
        chk("rb_rdata", dmem_rdata, 32'h1122A544);

        // Half write 0xBEEF @0xE
        drv(0, 0, 1, 1, 2'b01, 32'hE, 32'h0000BEEF);
        chk("wh_mask", sram_wmask[7:4], 4'b1100);
        chk("wh_din", sram_din[63:32], 32'hBEEFBEEF);
        tick();
        drv(0, 0, 1, 0, 2'b10, 32'hC, 0);
        tick();
        chk("rh_rdata", dmem_rdata, 32'hBEEFA544);

        // Preload @0x0 and @0x4, then parallel imem/dmem on different banks
        drv(0, 0, 1, 1, 2'b10, 32'h0, 32'hCAFE0000);
        tick();
        drv(0, 0, 1, 1, 2'b10, 32'h4, 32'h0000F00D);
        tick();
        drv(1, 32'h0, 1, 0, 2'b10, 32'h4, 0);
        chk("par_acks", {imem_ack, dmem_ack}, 2'b11);
        chk("par_csb", sram_csb, 2'b00);
        chk("par_addr", sram_addr, 18'd0);
        tick();
        chk("par_resp", {imem_resp, dmem_resp}, 4'b0101);
        chk("par_irdata", imem_rdata, 32'hCAFE0000);
        chk("par_drdata", dmem_rdata, 32'h0000F00D);

        // Same-bank conflict held for 4 cycles: dmem, imem, dmem, imem
        drv(1, 32'h0, 1, 0, 2'b10, 32'h8, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cf%0d_acks", k), {imem_ack, dmem_ack}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            if (k % 2 == 0) begin
                chk($sformatf("cf%0d_resp", k), {imem_resp, dmem_resp}, 4'b0001);
                chk($sformatf("cf%0d_rdata", k), dmem_rdata, 32'hDEADBEEF);
            end else begin
                chk($sformatf("cf%0d_resp", k), {imem_resp, dmem_resp}, 4'b0100);
                chk($sformatf("cf%0d_rdata", k), imem_rdata, 32'hCAFE0000);
            end
        end

        // dmem error cases: acked, no select, ER with zero data
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1, 0, ew[k], ea[k], 0);
            chk($sformatf("er%0d_ack", k), dmem_ack, 1);
            chk($sformatf("er%0d_csb", k), sram_csb, 2'b11);
            tick();
            chk($sformatf("er%0d_resp", k), dmem_resp, 2'b10);
            chk($sformatf("er%0d_rdata", k), dmem_rdata, 0);
        end

        // Misaligned fetch
        drv(1, 32'h2, 0, 0, 2'b10, 0, 0);
        chk("ier_ack", imem_ack, 1);
        chk("ier_csb", sram_csb, 2'b11);
        tick();
        chk("ier_resp", imem_resp, 2'b10);
        chk("ier_rdata", imem_rdata, 0);

        // Error request never contends, even on the fetch's bank
        drv(1, 32'h0, 1, 0, 2'b10, 32'h1000, 0);
        chk("nc_acks", {imem_ack, dmem_ack}, 2'b11);
        chk("nc_csb", sram_csb, 2'b10);
        tick();
        chk("nc_resp", {imem_resp, dmem_resp}, 4'b0110);

        // One more conflict (dmem wins) leaves the pointer favouring imem
        drv(1, 32'h0, 1, 0, 2'b10, 32'h8, 0);
        chk("pre_acks", {imem_ack, dmem_ack}, 2'b01);
        tick();

        // Mid-operation reset right after an acknowledged read
        drv(0, 0, 1, 0, 2'b10, 32'h8, 0);
        chk("mid_ack", dmem_ack, 1);
        tick();
        chk("mid_resp_before", dmem_resp, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("mid_resp_async", dmem_resp, 0);
        chk("mid_rdata_async", dmem_rdata, 0);
        chk("mid_ack_low", dmem_ack, 0);
        chk("mid_csb", sram_csb, 2'b11);
        tick();
        chk("mid_resp_held", dmem_resp, 0);
        @(negedge clk);
        dmem_req = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_resp", {imem_resp, dmem_resp}, 0);

        // First post-reset conflict goes to dmem
        drv(1, 32'h0, 1, 0, 2'b10, 32'h8, 0);
        chk("post_acks", {imem_ack, dmem_ack}, 2'b01);
        tick();
        chk("post_resp", {imem_resp, dmem_resp}, 4'b0001);
        chk("post_rdata", dmem_rdata, 32'hDEADBEEF);
        drv(0, 0, 0, 0, 2'b10, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
